// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings and helpers for the data-memory access controller.
// Holds the access-size and FSM-state enums plus the alignment check.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Reserved size always faults; halfwords need even, words 4-byte alignment.
  function automatic logic misaligned(input size_e size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = |lane;
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_ctrl_lane.sv
// Byte/halfword lane handling: load extraction with sign/zero extension,
// and store merge of new data into an existing little-endian word.
module lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane_addr,
  input  size_e       size,
  input  logic        sext,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_sh = {lane_addr, 3'b000};
  assign half_sh = {lane_addr[1], 4'b0000};
  assign byte_v  = rd_word[byte_sh +: 8];
  assign half_v  = rd_word[half_sh +: 16];

  always_comb begin
    load_val = rd_word;
    case (size)
      SZ_BYTE: load_val = {{24{sext & byte_v[7]}}, byte_v};
      SZ_HALF: load_val = {{16{sext & half_v[15]}}, half_v};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    merged = rd_word;
    case (size)
      SZ_BYTE: merged[byte_sh +: 8]  = wdata[7:0];
      SZ_HALF: merged[half_sh +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: one load/store at a time against a
// word-wide single-port RAM, sub-word stores done by read-modify-write.
module dmem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout
);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  size_e             size_q, size_d;
  logic              sext_q, sext_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merged_q, merged_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       load_val;
  logic [31:0]       merged_w;
  logic              bad;
  logic              we;

  lane_unit u_lane (
    .rd_word   (ram_dout),
    .lane_addr (addr_q[1:0]),
    .size      (size_q),
    .sext      (sext_q),
    .wdata     (wdata_q),
    .load_val  (load_val),
    .merged    (merged_w)
  );

  assign bad = misaligned(size_q, addr_q[1:0]);

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    size_d   = size_q;
    sext_d   = sext_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    we       = 1'b0;
    ram_din  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          wr_d    = wr;
          size_d  = size_e'(size);
          sext_d  = sext;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (bad) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (!wr_q) begin
          rdata_d = load_val;
          state_d = ST_DONE;
        end else if (size_q == SZ_WORD) begin
          we      = 1'b1;
          ram_din = wdata_q;
          state_d = ST_DONE;
        end else begin
          merged_d = merged_w;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        we      = 1'b1;
        ram_din = merged_q;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      sext_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      sext_q   <= sext_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Write enable is combinational, so reset must mask it directly to abort a pending write.
  assign ram_we   = we & ~rst;
  assign ram_addr = addr_q[ADDR_W+1:2];
  assign ready    = (state_q == ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = done & err_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized self-checking bench for dmem_ctrl against a byte-array memory
// model; directed cases cover RMW stores, extension, faults and reset abort.
module tb_dmem_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned NWORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [31:0]       ram_dout;

  logic [31:0] ram [NWORDS];
  logic [7:0]  ref_mem [NWORDS*4];
  logic [31:0] ref_rdata;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wr       (wr),
    .size     (size),
    .sext     (sext),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  assign ram_dout = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_word(input int unsigned wa);
    return {ref_mem[wa*4+3], ref_mem[wa*4+2], ref_mem[wa*4+1], ref_mem[wa*4]};
  endfunction

  task automatic drive_junk();
    req   = 1'($urandom_range(0, 1));
    wr    = 1'($urandom_range(0, 1));
    size  = 2'($urandom_range(0, 3));
    sext  = 1'($urandom_range(0, 1));
    addr  = (ADDR_W+2)'($urandom);
    wdata = $urandom;
  endtask

  // One transaction; called when the DUT is (or is about to be) idle.
  task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                       input int unsigned a, input logic [31:0] wd, input bit junk);
    int unsigned nb;
    bit          bad;
    int          exp_done;
    int          exp_we;
    int          waited;
    bit          seen;
    logic [31:0] v;
    nb       = 1 << sz;
    bad      = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    exp_done = (w && !bad && sz != 2'd2) ? 3 : 2;
    exp_we   = (!w || bad) ? 0 : ((sz == 2'd2) ? 1 : 2);
    waited   = 0;
    seen     = 1'b0;
    while (!ready && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!ready) begin
      check_eq("ready_timeout", 32'(ready), 32'd1);
      return;
    end
    req = 1'b1; wr = w; size = sz; sext = sx; addr = a[ADDR_W+1:0]; wdata = wd;
    @(posedge clk); #1;
    if (!bad) begin
      if (w) begin
        for (int unsigned i = 0; i < nb; i++) ref_mem[a+i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int unsigned i = 0; i < nb; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
        if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        ref_rdata = v;
      end
    end
    for (int c = 1; c <= 6 && !seen; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 1) check_eq("busy_ready", 32'(ready), 32'd0);
      check_eq("we_cycle", 32'(ram_we), 32'(c == exp_we));
      if (done) begin
        seen = 1'b1;
        check_eq("done_lat", 32'(c), 32'(exp_done));
        check_eq("err", 32'(err), 32'(bad));
        check_eq("rdata", rdata, ref_rdata);
        if (junk) drive_junk(); else req = 1'b0;
      end else if (junk) begin
        drive_junk();
      end
    end
    if (!seen) check_eq("done_timeout", 32'(done), 32'd1);
    check_eq("ram_word", ram[a>>2], ref_word(a>>2));
    @(posedge clk); #1;
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("ready_ret", 32'(ready), 32'd1);
    check_eq("rdata_hold", rdata, ref_rdata);
  endtask

  initial begin
    int unsigned a;
    for (int unsigned i = 0; i < NWORDS; i++) ram[i] = '0;
    for (int unsigned i = 0; i < NWORDS*4; i++) ref_mem[i] = '0;
    ref_rdata = '0;
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = '0; sext = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_we", 32'(ram_we), 32'd0);
    check_eq("rst_din", ram_din, 32'd0);
    check_eq("rst_raddr", 32'(ram_addr), 32'd0);
    rst = 1'b0;

    do_op(1'b1, 2'd2, 1'b0, 'h010, 32'h1234_5678, 1'b0);
    do_op(1'b0, 2'd2, 1'b0, 'h010, 32'h0, 1'b0);
    check_eq("tp_sw_lw", rdata, 32'h1234_5678);
    do_op(1'b1, 2'd0, 1'b0, 'h012, 32'h0000_00AB, 1'b0);
    check_eq("tp_sb_rmw", ram[4], 32'h12AB_5678);

    do_op(1'b1, 2'd2, 1'b0, 0, 32'hFF80_7F01, 1'b0);
    do_op(1'b0, 2'd0, 1'b1, 2, 32'h0, 1'b0);
    check_eq("tp_lb", rdata, 32'hFFFF_FF80);
    do_op(1'b0, 2'd0, 1'b0, 2, 32'h0, 1'b0);
    check_eq("tp_lbu", rdata, 32'h0000_0080);
    do_op(1'b0, 2'd1, 1'b1, 2, 32'h0, 1'b0);
    check_eq("tp_lh", rdata, 32'hFFFF_FF80);
    do_op(1'b0, 2'd1, 1'b0, 0, 32'h0, 1'b0);
    check_eq("tp_lhu", rdata, 32'h0000_7F01);

    do_op(1'b1, 2'd2, 1'b0, 'h011, 32'hDEAD_BEEF, 1'b0);
    check_eq("tp_sw_mis", ram[4], 32'h12AB_5678);
    do_op(1'b0, 2'd1, 1'b1, 'h003, 32'h0, 1'b0);
    check_eq("tp_lh_mis", rdata, 32'h0000_7F01);
    do_op(1'b0, 2'd3, 1'b0, 'h020, 32'h0, 1'b0);

    // Reset during the WRITE cycle of a byte store.
    req = 1'b1; wr = 1'b1; size = 2'd0; sext = 1'b0; addr = 'h012; wdata = 32'h0000_00CD;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_we", 32'(ram_we), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_we_gate", 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_rdata = '0;
    check_eq("abort_ram", ram[4], ref_word(4));
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_ready", 32'(ready), 32'd1);
    check_eq("abort_rdata", rdata, 32'd0);
    check_eq("abort_raddr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1;
    check_eq("abort_nodone", 32'(done), 32'd0);

    do_op(1'b0, 2'd2, 1'b0, 'h010, 32'h0, 1'b1);
    do_op(1'b0, 2'd1, 1'b1, 'h000, 32'h0, 1'b1);
    check_eq("b2b_second", rdata, 32'h0000_7F01);

    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NWORDS*4-1) : $urandom_range(0, 63);
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, 1'($urandom_range(0, 1)));
    end
    req = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the CPU load/store stage and the single-port, word-wide data RAM (combinational read, synchronous write on `clk` with one word-wide write enable). It accepts one byte, halfword or word load/store request at a time. It performs sub-word stores by read-modify-write and sub-word loads by lane extraction with sign or zero extension. Results return to the CPU with a one-cycle `done` pulse.

## Interface

- `ADDR_W`, default 10: RAM word-address width. The CPU byte address is `ADDR_W+2` bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req` input 1: request valid; sampled only while `ready`=1.
- `wr` input 1: 1 = store, 0 = load.
- `size` input 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `sext` input 1: sign-extend a sub-word load (ignored for stores and words).
- `addr` input ADDR_W+2: byte address.
- `wdata` input 32: store data; the value sits in the low bits for sub-word stores.
- `ready` output 1: controller idle, can accept `req`.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: misalignment/reserved-size flag, valid with `done`.
- `rdata` output 32: load result, valid from the `done` cycle; holds its value until the next load completes.
- `ram_addr` output ADDR_W: word address to RAM.
- `ram_din` output 32: write data to RAM.
- `ram_we` output 1: RAM write enable.
- `ram_dout` input 32: RAM read data, combinational from `ram_addr`.

## Operation

- **States:** IDLE, ACCESS, WRITE, DONE. `ready` = (state==IDLE).
- **IDLE:**
  - `req`=1 registers `wr`, `size`, `sext`, `addr` and `wdata`, then moves to ACCESS.
  - `req`=0 stays in IDLE.
- **ACCESS:**
  - `ram_addr` = registered `addr[ADDR_W+1:2]`.
  - Misaligned → DONE with `err` set and no RAM write. Misaligned means `size`=11, halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Load: extract lane from `ram_dout`, extend, register into `rdata`; → DONE.
  - Word store: `ram_we`=1, `ram_din`=`wdata`; → DONE.
  - Sub-word store: register the merged word (`ram_dout` with the target lane replaced by `wdata` low bits); → WRITE.
- **WRITE:** `ram_we`=1, `ram_din`=merged word; → DONE.
- **DONE:** `done`=1 and `err` as flagged; → IDLE.
- **Byte lanes (little-endian):**
  - Byte at `addr[1:0]`=k occupies bits 8k+7:8k.
  - Halfword at `addr[1]`=h occupies bits 16h+15:16h.
- **Extension:** `sext`=1 replicates the lane MSB into the upper bits; `sext`=0 zero-fills.
- **Errored load:** `rdata` is not updated.
- **`ram_we` gating:** `ram_we` is gated by `!rst`. No RAM write occurs on any edge where `rst` is high.

## Timing

- Request sampled on edge T (IDLE, `req`=1).
- Load: ACCESS in cycle T+1, `done`/`rdata` in T+2, `ready` again in T+3.
- Word store: `ram_we` in T+1, `done` in T+2.
- Sub-word store: read in T+1, `ram_we` in T+2, `done` in T+3.
- Misaligned access: `done`+`err` in T+2, no RAM write.
- `req` while `ready`=0 is ignored. The CPU holds `req` until it sees `ready`.
- **Reset values:** state IDLE, `ready`=1, `done`=0, `err`=0, `rdata`=0, `ram_we`=0, `ram_din`=0, `ram_addr`=0 (registered address cleared).
- **Reset mid-operation:** the transaction is aborted. No RAM write happens, even if `rst` is asserted in the WRITE cycle. No `done` pulse follows.

## Structure

- Package `mem_pkg` holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - the state enum;
  - a misalignment-check function.
- Sub-module `lane_unit` (combinational) provides:
  - extract+extend (inputs: word, `addr[1:0]`, `size`, `sext`);
  - merge (inputs: old word, `wdata`, `addr[1:0]`, `size`).
- `dmem_ctrl` itself contains only the FSM and the request/result registers.

## Test plan

- Word store then load: store 0x12345678 to byte addr 0x010, load word from 0x010. Required: RAM word 4 = 0x12345678, `rdata`=0x12345678, `done` at T+2 for both, `err`=0.
- Byte store RMW: word 4 = 0x12345678, `sb` 0xAB at addr 0x012. Required: `ram_we` only in T+2, word 4 = 0x12AB5678, `done` at T+3.
- Sub-word loads from word 0xFF80_7F01 at addr 0:
  - `lb` addr 2, `sext`=1 → 0xFFFFFF80;
  - `lbu` addr 2 → 0x00000080;
  - `lh` addr 2, `sext`=1 → 0xFFFFFF80;
  - `lhu` addr 0 → 0x00007F01.
- Misalignment:
  - `sw` to addr 0x011 → `err`=1 with `done` at T+2, no `ram_we`, RAM unchanged.
  - `lh` at addr 0x003 → `err`=1, `rdata` unchanged.
  - `size`=11 → `err`=1.
- Reset in WRITE cycle of an `sb`: `ram_we` stays 0, RAM unchanged, no `done`, `ready`=1 the cycle after reset.
- Back-to-back: hold `req` high across two loads. Required: the second is accepted only in the cycle `ready` returns, `done` pulses are exactly one cycle each, and `req` during busy cycles is ignored.
